muldiv_unit: RTL

Iterative, parametrised multiply/divide unit implementing the RV32M/RV64M M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It is the multi-cycle successor to the single-cycle ALU datapath. It sits beside the ALU in the execute stage and is driven by the control path through a start/busy/done handshake. It computes one result bit per cycle and resolves the RISC-V divide-by-zero and overflow corner cases in a single cycle.

---
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide, one result bit per clock, with divide-by-zero/overflow resolved at start.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN:0] acc_q, acc_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand conditioning on the incoming request
  logic            signed1, signed2, s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            is_div_i, is_rem_i, div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  assign is_div_i = op_i[2];
  assign is_rem_i = op_i[1];
  assign signed1  = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                    (op_i == OP_DIV) || (op_i == OP_REM);
  assign signed2  = (op_i == OP_MUL) || (op_i == OP_MULH) ||
                    (op_i == OP_DIV) || (op_i == OP_REM);
  assign s1       = signed1 & data1_i[XLEN-1];
  assign s2       = signed2 & data2_i[XLEN-1];
  assign mag1     = s1 ? (~data1_i + 1'b1) : data1_i;
  assign mag2     = s2 ? (~data2_i + 1'b1) : data2_i;
  assign div_zero = is_div_i && (data2_i == '0);
  assign div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                    (data1_i == {1'b1, {(XLEN-1){1'b0}}}) && (data2_i == '1);

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = is_rem_i ? data1_i : '1;
    else if (div_ovf) special_res = is_rem_i ? '0 : data1_i;
  end

  // One iteration step; acc holds {hi/remainder (XLEN+1), lo/multiplier-or-quotient (XLEN)}
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [2*XLEN:0] mul_next, div_next, step;

  assign mul_sum   = acc_q[2*XLEN:XLEN] + {1'b0, (acc_q[0] ? opb_q : '0)};
  assign mul_next  = {1'b0, mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_next  = {(div_diff[XLEN] ? div_shift : div_diff), acc_q[XLEN-2:0], ~div_diff[XLEN]};
  assign step      = op_q[2] ? div_next : mul_next;

  // Sign correction of the final step result
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   div_val, div_s, final_res;

  assign prod    = step[2*XLEN-1:0];
  assign prod_s  = neg_q ? (~prod + 1'b1) : prod;
  assign div_val = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
  assign div_s   = neg_q ? (~div_val + 1'b1) : div_val;

  always_comb begin
    if (op_q[2])              final_res = div_s;
    else if (op_q == OP_MUL)  final_res = prod_s[XLEN-1:0];
    else                      final_res = prod_s[2*XLEN-1:XLEN];
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          op_d  = op_i;
          neg_d = ((op_i == OP_REM) || (op_i == OP_REMU)) ? s1 : (s1 ^ s2);
          acc_d = {{(XLEN+1){1'b0}}, (is_div_i ? mag1 : mag2)};
          opb_d = is_div_i ? mag2 : mag1;
          cnt_d = CW'(XLEN);
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = final_res;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything except reset and never disturbs the held result
    if (flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the datapath registers are
  // reset too, so a restarted unit never computes from stale accumulator contents.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == CALC);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule
